// File: rtl/fc_layer_gen.sv
// fc_layer_gen: fully-connected layer y = act(W*x + b) with P MAC lanes and external weight/bias ROMs
module fc_layer_gen #(
    parameter int M = 8,
    parameter int N = 8,
    parameter int T = 16,
    parameter int P = 1,
    parameter int FRAC = 0,
    parameter int RELU = 1,
    localparam int G = M / P,
    localparam int AW = $clog2(M * N / P),
    localparam int BW = G > 1 ? $clog2(G) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            input_valid,
    output logic            input_ready,
    input  logic [T-1:0]    input_data,
    output logic            output_valid,
    input  logic            output_ready,
    output logic [T-1:0]    output_data,
    output logic [AW-1:0]   w_addr,
    input  logic [P*T-1:0]  w_data,
    output logic [BW-1:0]   b_addr,
    input  logic [P*T-1:0]  b_data
);
    localparam int ACCW = 2 * T + $clog2(N) + 1;
    localparam int CW = $clog2(N + 2);
    localparam int JW = $clog2(N);
    localparam int LW = P > 1 ? $clog2(P) : 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t state, next;
    logic armed, in_fire, out_fire, last_j, last_c, last_lane, last_g, mac;
    logic [JW-1:0] j, xi;
    logic [CW-1:0] c;
    logic [BW-1:0] g;
    logic [LW-1:0] lane;
    logic signed [T-1:0] x [N];
    logic signed [ACCW-1:0] acc [P];
    logic signed [ACCW-1:0] bext [P];
    logic signed [2*T-1:0] prod [P];
    logic signed [T-1:0] res [P];

    function automatic logic signed [T-1:0] sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] r, hi, lo;
        hi = {{(ACCW-T+1){1'b0}}, {(T-1){1'b1}}};
        lo = ~hi;
        r = a >>> FRAC;
        r = r > hi ? hi : r < lo ? lo : r;
        if (RELU != 0 && r < 0) r = '0;
        return r[T-1:0];
    endfunction

    // handshakes, counter terminals, ROM addresses, outputs and next state
    always_comb begin
        input_ready = state == LOAD && armed;
        output_valid = state == OUTPUT;
        output_data = output_valid ? res[lane] : '0;
        in_fire = input_valid && input_ready;
        out_fire = output_valid && output_ready;
        last_j = j == JW'(N - 1);
        last_c = c == CW'(N + 1);
        last_lane = lane == LW'(P - 1);
        last_g = g == BW'(G - 1);
        mac = state == COMPUTE && c != '0 && c <= CW'(N);
        xi = JW'(c - 1'b1);
        w_addr = state == COMPUTE && int'(c) < N ? AW'(int'(g) * N + int'(c)) : '0;
        b_addr = state == COMPUTE ? g : '0;
        next = state == LOAD ? (in_fire && last_j ? COMPUTE : LOAD) :
               state == COMPUTE ? (last_c ? OUTPUT : COMPUTE) :
               (out_fire && last_lane ? (last_g ? LOAD : COMPUTE) : OUTPUT);
    end

    // per-lane product of the returning weight and the sign-extended bias
    always_comb begin
        for (int p = 0; p < P; p++) begin
            prod[p] = x[xi] * $signed(w_data[p*T +: T]);
            bext[p] = $signed(b_data[p*T +: T]);
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else state <= next;
    end

    // input buffer, counters, accumulators and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
            j <= '0;
            c <= '0;
            g <= '0;
            lane <= '0;
            for (int n = 0; n < N; n++) x[n] <= '0;
            for (int p = 0; p < P; p++) begin
                acc[p] <= '0;
                res[p] <= '0;
            end
        end else begin
            armed <= 1'b1;
            if (in_fire) begin
                x[j] <= input_data;
                j <= last_j ? '0 : j + 1'b1;
            end
            if (state == COMPUTE) c <= last_c ? '0 : c + 1'b1;
            for (int p = 0; p < P; p++) begin
                if (mac) acc[p] <= (c == CW'(1) ? bext[p] <<< FRAC : acc[p]) + prod[p];
                if (state == COMPUTE && last_c) res[p] <= sat(acc[p]);
            end
            if (out_fire) begin
                lane <= last_lane ? '0 : lane + 1'b1;
                if (last_lane) g <= last_g ? '0 : g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fc_layer_gen.sv
// tb_fc_layer_gen: three layer variants (plain, ReLU, Q8) run in lockstep against a behavioural model
module tb_fc_layer_gen;
    logic clk = 0, rst = 1, input_valid = 0, output_ready = 1;
    logic [15:0] input_data = 0;
    logic [2:0] ov, ir;
    logic [2:0][15:0] od;
    shortint W [4][4];
    shortint B [4];
    shortint X [4];
    int exp_q [3][$];
    int pass = 0, total = 0, stall = 0;
    bit stall_arm = 0, rnd_ready = 0, rnd_gap = 0;
    bit held [3];
    int hold_d [3];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int FR = (i == 2) ? 8 : 0;
        localparam int RL = (i == 1) ? 1 : 0;
        logic rdy, vld, ba;
        logic [15:0] dat;
        logic [2:0] wa;
        logic [31:0] wd, bd;
        fc_layer_gen #(.M(4), .N(4), .T(16), .P(2), .FRAC(FR), .RELU(RL)) dut (
            .clk(clk), .reset(rst), .input_valid(input_valid), .input_ready(rdy),
            .input_data(input_data), .output_valid(vld), .output_ready(output_ready),
            .output_data(dat), .w_addr(wa), .w_data(wd), .b_addr(ba), .b_data(bd));
        assign ov[i] = vld;
        assign od[i] = dat;
        assign ir[i] = rdy;
        always @(posedge clk) begin
            wd <= {W[int'(wa[2]) * 2 + 1][wa[1:0]], W[int'(wa[2]) * 2][wa[1:0]]};
            bd <= {B[int'(ba) * 2 + 1], B[int'(ba) * 2]};
        end
    end

    function automatic int model(int fr, int rl, int n);
        longint a = longint'(B[n]) <<< fr;
        for (int j = 0; j < 4; j++) a += longint'(X[j]) * longint'(W[n][j]);
        a = a >>> fr;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        if (rl != 0 && a < 0) a = 0;
        return int'(a);
    endfunction

    function automatic shortint rnd();
        if ($urandom_range(0, 1) == 1) return shortint'($urandom);
        return shortint'(int'($urandom_range(0, 200)) - 100);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_exp();
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 4; n++) exp_q[k].push_back(model(k == 2 ? 8 : 0, k == 1 ? 1 : 0, n));
    endtask

    task automatic send(input shortint xv [4]);
        int j = 0, guard = 0;
        X = xv;
        while (j < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (rnd_gap && $urandom_range(0, 3) == 0) input_valid = 0;
            else begin
                input_valid = 1;
                input_data = xv[j];
                if (ir[0]) j++;
            end
        end
        if (j < 4) chk("input_timeout", j, 4);
        @(negedge clk);
        input_valid = 0;
        push_exp();
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) chk("drain_timeout", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (stall_arm && ov[0]) begin
            stall_arm = 0;
            stall = 5;
        end
        output_ready = stall > 0 ? 1'b0 : rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stall > 0) stall--;
        for (int k = 0; k < 3; k++) begin
            if (rst) held[k] = 0;
            else begin
                if (exp_q[k].size() != 0) chk($sformatf("busy_input_ready%0d", k), int'(ir[k]), 0);
                if (held[k]) begin
                    chk($sformatf("held_valid%0d", k), int'(ov[k]), 1);
                    chk($sformatf("held_data%0d", k), int'($signed(od[k])), hold_d[k]);
                end
                if (ov[k] && output_ready) begin
                    if (exp_q[k].size() == 0) chk($sformatf("spurious_out%0d", k), 1, 0);
                    else chk($sformatf("y_inst%0d", k), int'($signed(od[k])), exp_q[k].pop_front());
                    held[k] = 0;
                end else begin
                    held[k] = ov[k];
                    hold_d[k] = int'($signed(od[k]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        shortint v [4];
        int cnt;
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_output_valid", int'(ov[0]), 0);
        chk("rst_output_data", int'(od[0]), 0);
        chk("rst_input_ready", int'(ir[0]), 0);
        chk("rst_w_addr", int'(g_dut[0].wa), 0);
        chk("rst_b_addr", int'(g_dut[0].ba), 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", int'(ir[0]), 1);

        W = '{'{1, 1, 1, 1}, '{-1, -1, -1, -1}, '{0, 0, 0, 2}, '{1, 0, 0, 0}};
        B = '{5, 0, -3, 0};
        v = '{1, 2, 3, 4};
        send(v);
        chk("pin_plain_n0", model(0, 0, 0), 15);
        chk("pin_plain_n1", model(0, 0, 1), -10);
        chk("pin_plain_n2", model(0, 0, 2), 5);
        chk("pin_plain_n3", model(0, 0, 3), 1);
        chk("pin_relu_n1", model(0, 1, 1), 0);
        cnt = 0;
        while (!ov[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", cnt + 1, 4 + 3);
        drain();

        W = '{'{32767, 32767, 32767, 32767}, '{-32767, -32767, -32767, -32767}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        B = '{0, 0, 0, 0};
        v = '{32767, 32767, 32767, 32767};
        send(v);
        chk("pin_sat_hi", model(0, 0, 0), 32767);
        chk("pin_sat_lo", model(0, 0, 1), -32768);
        drain();

        W = '{'{512, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        v = '{384, 0, 0, 0};
        send(v);
        chk("pin_q8", model(8, 0, 0), 768);
        drain();
        B[0] = -256;
        send(v);
        chk("pin_q8_bias", model(8, 0, 0), 512);
        drain();

        W = '{'{1, 1, 1, 1}, '{-1, -1, -1, -1}, '{0, 0, 0, 2}, '{1, 0, 0, 0}};
        B = '{5, 0, -3, 0};
        v = '{1, 2, 3, 4};
        stall_arm = 1;
        send(v);
        drain();
        v = '{-7, 9, 100, -3};
        send(v);
        drain();

        v = '{1, 2, 3, 4};
        send(v);
        repeat (2) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("abort_output_valid", int'(ov[0]), 0);
        chk("abort_output_data", int'(od[0]), 0);
        chk("abort_input_ready", int'(ir[0]), 0);
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        v = '{4, 3, 2, 1};
        send(v);
        drain();

        rnd_ready = 1;
        rnd_gap = 1;
        repeat (25) begin
            for (int n = 0; n < 4; n++) begin
                B[n] = rnd();
                v[n] = rnd();
                for (int j = 0; j < 4; j++) W[n][j] = rnd();
            end
            send(v);
            drain();
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
